axi_dma_desc_mux_credit: RTL



---
 rtl/axi_dma_desc_mux_credit_if.sv | 60 ++++++
 rtl/axi_dma_desc_mux_credit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/axi_dma_desc_mux_credit_if.sv
// Descriptor/status bundle for the credit-limited descriptor mux.
// The slave modport is the mux; the master modport is the sources plus the DMA core.
interface axi_dma_desc_mux_credit_if #(
  parameter int PORTS          = 4,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int LEN_WIDTH      = 20,
  parameter int S_TAG_WIDTH    = 8,
  parameter int M_TAG_WIDTH    = S_TAG_WIDTH + $clog2(PORTS),
  parameter int USER_WIDTH     = 1
);
  logic [PORTS*AXI_ADDR_WIDTH-1:0] s_axis_desc_addr;
  logic [PORTS*LEN_WIDTH-1:0]      s_axis_desc_len;
  logic [PORTS*S_TAG_WIDTH-1:0]    s_axis_desc_tag;
  logic [PORTS*USER_WIDTH-1:0]     s_axis_desc_user;
  logic [PORTS-1:0]                s_axis_desc_valid;
  logic [PORTS-1:0]                s_axis_desc_ready;

  logic [AXI_ADDR_WIDTH-1:0]       m_axis_desc_addr;
  logic [LEN_WIDTH-1:0]            m_axis_desc_len;
  logic [M_TAG_WIDTH-1:0]          m_axis_desc_tag;
  logic [USER_WIDTH-1:0]           m_axis_desc_user;
  logic                            m_axis_desc_valid;
  logic                            m_axis_desc_ready;

  logic [LEN_WIDTH-1:0]            s_axis_desc_status_len;
  logic [M_TAG_WIDTH-1:0]          s_axis_desc_status_tag;
  logic [3:0]                      s_axis_desc_status_error;
  logic                            s_axis_desc_status_valid;

  logic [PORTS*LEN_WIDTH-1:0]      m_axis_desc_status_len;
  logic [PORTS*S_TAG_WIDTH-1:0]    m_axis_desc_status_tag;
  logic [PORTS*4-1:0]              m_axis_desc_status_error;
  logic [PORTS-1:0]                m_axis_desc_status_valid;

  modport slave (
    input  s_axis_desc_addr, s_axis_desc_len, s_axis_desc_tag, s_axis_desc_user,
    input  s_axis_desc_valid,
    output s_axis_desc_ready,
    output m_axis_desc_addr, m_axis_desc_len, m_axis_desc_tag, m_axis_desc_user,
    output m_axis_desc_valid,
    input  m_axis_desc_ready,
    input  s_axis_desc_status_len, s_axis_desc_status_tag, s_axis_desc_status_error,
    input  s_axis_desc_status_valid,
    output m_axis_desc_status_len, m_axis_desc_status_tag, m_axis_desc_status_error,
    output m_axis_desc_status_valid
  );

  modport master (
    output s_axis_desc_addr, s_axis_desc_len, s_axis_desc_tag, s_axis_desc_user,
    output s_axis_desc_valid,
    input  s_axis_desc_ready,
    input  m_axis_desc_addr, m_axis_desc_len, m_axis_desc_tag, m_axis_desc_user,
    input  m_axis_desc_valid,
    output m_axis_desc_ready,
    output s_axis_desc_status_len, s_axis_desc_status_tag, s_axis_desc_status_error,
    output s_axis_desc_status_valid,
    input  m_axis_desc_status_len, m_axis_desc_status_tag, m_axis_desc_status_error,
    input  m_axis_desc_status_valid
  );
endinterface

// File: rtl/axi_dma_desc_mux_credit.sv
// Credit-limited descriptor mux: arbitrates PORTS descriptor streams onto one DMA core,
// prefixes tags with the source port index and routes returning status back by that prefix.
module axi_dma_desc_mux_credit #(
  parameter int    PORTS           = 4,
  parameter int    AXI_ADDR_WIDTH  = 16,
  parameter int    LEN_WIDTH       = 20,
  parameter int    S_TAG_WIDTH     = 8,
  parameter int    M_TAG_WIDTH     = S_TAG_WIDTH + $clog2(PORTS),
  parameter int    USER_WIDTH      = 1,
  parameter string ARB_TYPE        = "ROUND_ROBIN",
  parameter int    MAX_OUTSTANDING = 4,
  parameter int    CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  axi_dma_desc_mux_credit_if.slave   bus,
  output logic [PORTS*CNT_WIDTH-1:0] outstanding,
  output logic [PORTS-1:0]           underflow_err,
  output logic                       route_err,
  output logic                       idle
);
  localparam int IDX_BITS = $clog2(PORTS);
  localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam bit ARB_RR   = (ARB_TYPE == "ROUND_ROBIN");
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

  if (M_TAG_WIDTH < S_TAG_WIDTH + IDX_BITS) begin : g_bad_tag_width
    $error("M_TAG_WIDTH must be at least S_TAG_WIDTH + $clog2(PORTS)");
  end
  if (ARB_TYPE != "ROUND_ROBIN" && ARB_TYPE != "PRIORITY") begin : g_bad_arb_type
    $error("ARB_TYPE must be ROUND_ROBIN or PRIORITY");
  end

  logic [IDX_W-1:0]          last_grant_reg;
  logic [AXI_ADDR_WIDTH-1:0] m_addr_reg;
  logic [LEN_WIDTH-1:0]      m_len_reg;
  logic [M_TAG_WIDTH-1:0]    m_tag_reg;
  logic [USER_WIDTH-1:0]     m_user_reg;
  logic                      m_valid_reg;
  logic [LEN_WIDTH-1:0]      st_len_reg;
  logic [S_TAG_WIDTH-1:0]    st_tag_reg;
  logic [3:0]                st_error_reg;
  logic [PORTS-1:0]          st_valid_reg;
  logic                      route_err_reg;

  logic [PORTS-1:0]          eligible;
  logic                      grant_valid;
  logic [IDX_W-1:0]          grant_idx;
  int                        sel;
  logic                      slot_free;
  logic                      accept;
  logic [M_TAG_WIDTH-1:0]    m_tag_next;
  logic [IDX_W-1:0]          st_idx;
  logic                      st_idx_ok;
  logic                      st_fire;

  function automatic int search_slot(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= PORTS) s = s - PORTS;
    return s;
  endfunction

  // Walk the search order backwards so the first eligible port in that order wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    sel         = 0;
    for (int i = PORTS; i >= 1; i--) begin
      sel = ARB_RR ? search_slot(last_grant_reg, i) : (i - 1);
      if (eligible[sel]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(sel);
      end
    end
  end

  assign slot_free  = !m_valid_reg || bus.m_axis_desc_ready;
  assign accept     = slot_free && grant_valid;
  assign m_tag_next = M_TAG_WIDTH'({grant_idx,
                       bus.s_axis_desc_tag[int'(grant_idx)*S_TAG_WIDTH +: S_TAG_WIDTH]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= IDX_W'(PORTS - 1);
      m_addr_reg     <= '0;
      m_len_reg      <= '0;
      m_tag_reg      <= '0;
      m_user_reg     <= '0;
      m_valid_reg    <= 1'b0;
    end else if (accept) begin
      last_grant_reg <= grant_idx;
      m_addr_reg     <= bus.s_axis_desc_addr[int'(grant_idx)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
      m_len_reg      <= bus.s_axis_desc_len[int'(grant_idx)*LEN_WIDTH +: LEN_WIDTH];
      m_tag_reg      <= m_tag_next;
      m_user_reg     <= bus.s_axis_desc_user[int'(grant_idx)*USER_WIDTH +: USER_WIDTH];
      m_valid_reg    <= 1'b1;
    end else if (bus.m_axis_desc_ready) begin
      m_valid_reg    <= 1'b0;
    end
  end

  // With a single port there are no index bits, so every status belongs to port 0.
  if (PORTS > 1) begin : g_idx
    assign st_idx    = bus.s_axis_desc_status_tag[S_TAG_WIDTH +: IDX_W];
    assign st_idx_ok = (int'(st_idx) < PORTS);
  end else begin : g_idx_single
    assign st_idx    = '0;
    assign st_idx_ok = 1'b1;
  end

  assign st_fire = bus.s_axis_desc_status_valid && st_idx_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_len_reg    <= '0;
      st_tag_reg    <= '0;
      st_error_reg  <= '0;
      st_valid_reg  <= '0;
      route_err_reg <= 1'b0;
    end else begin
      st_valid_reg <= st_fire ? (PORTS'(1) << st_idx) : '0;
      if (st_fire) begin
        st_len_reg   <= bus.s_axis_desc_status_len;
        st_tag_reg   <= bus.s_axis_desc_status_tag[S_TAG_WIDTH-1:0];
        st_error_reg <= bus.s_axis_desc_status_error;
      end
      if (bus.s_axis_desc_status_valid && !st_idx_ok) route_err_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic                 uf_reg;
    logic                 inc;
    logic                 st_hit;
    logic                 dec;

    assign eligible[gi] = bus.s_axis_desc_valid[gi] && (cnt_reg < CNT_MAX);
    assign inc          = accept && (grant_idx == IDX_W'(gi));
    assign st_hit       = st_fire && (st_idx == IDX_W'(gi));
    assign dec          = st_hit && (cnt_reg != '0);

    // A credit returned on an empty counter is flagged but never wraps the count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
        uf_reg  <= 1'b0;
      end else begin
        if (inc && !dec)      cnt_reg <= cnt_reg + CNT_WIDTH'(1);
        else if (dec && !inc) cnt_reg <= cnt_reg - CNT_WIDTH'(1);
        if (st_hit && (cnt_reg == '0)) uf_reg <= 1'b1;
      end
    end

    assign bus.s_axis_desc_ready[gi] = accept && (grant_idx == IDX_W'(gi));
    assign outstanding[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
    assign underflow_err[gi] = uf_reg;
    assign bus.m_axis_desc_status_len[gi*LEN_WIDTH +: LEN_WIDTH]     = st_len_reg;
    assign bus.m_axis_desc_status_tag[gi*S_TAG_WIDTH +: S_TAG_WIDTH] = st_tag_reg;
    assign bus.m_axis_desc_status_error[gi*4 +: 4]                   = st_error_reg;
  end

  assign bus.m_axis_desc_addr         = m_addr_reg;
  assign bus.m_axis_desc_len          = m_len_reg;
  assign bus.m_axis_desc_tag          = m_tag_reg;
  assign bus.m_axis_desc_user         = m_user_reg;
  assign bus.m_axis_desc_valid        = m_valid_reg;
  assign bus.m_axis_desc_status_valid = st_valid_reg;
  assign route_err                    = route_err_reg;
  assign idle                         = (outstanding == '0) && !m_valid_reg;
endmodule
